// File: rtl/wfifo_frame_sched.sv
// wfifo_frame_sched: frame-granular round-robin of two pixel sources onto the 16-bit packer path, padding short frames to 16 px.
// Define WFS_TESTPAT_EN to add a colour-bar test-pattern source used when both enables are low.
module wfifo_frame_sched #(
    parameter int FRAME_PIX = 307200,
    parameter int LOAD_CYC  = 32,
    parameter int H_PIX     = 640
) (
    input  logic        rst_n,
    input  logic        wr_clk,
    input  logic        s0_en,
    input  logic        s1_en,
    input  logic        s0_vsync,
    input  logic        s1_vsync,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic [15:0] s0_data,
    input  logic [15:0] s1_data,
    output logic        wr_load,
    output logic        datain_valid,
    output logic [15:0] datain,
    output logic [1:0]  cur_src,
    output logic        frame_done,
    output logic        frame_short,
    output logic        busy
);
    localparam int PW = $clog2(FRAME_PIX + 1);
    localparam int LW = $clog2(LOAD_CYC);
    typedef enum logic [2:0] {ARB, WAIT_VS, LOAD, XFER, PAD, DONE} state_t;
    state_t        state_q, state_d;
    logic [1:0]    cur_src_q, cur_src_d;
    logic          last_q, last_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d, pix_inc;
    logic          short_q, short_d;
    logic [15:0]   datain_q, datain_d;
    logic          datain_valid_q, datain_valid_d;
    logic          s0_vsync_q, s1_vsync_q;
    logic          tp, sel_valid, sel_vs_edge, fwd;
    logic [15:0]   sel_data;
`ifdef WFS_TESTPAT_EN
    localparam int BAR_W = H_PIX / 8;
    localparam int BW = $clog2(BAR_W + 1);
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bar_q, bar_d;
    assign tp = cur_src_q == 2'd2;
    // bar index wraps mod 8 exactly at each line end
    always_comb begin
        bcnt_d = (state_q == XFER && bcnt_q != BW'(BAR_W - 1)) ? bcnt_q + 1'b1 : '0;
        bar_d  = state_q != XFER ? 3'd0 : (bcnt_q == BW'(BAR_W - 1)) ? bar_q + 1'b1 : bar_q;
    end
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            bar_q  <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            bar_q  <= bar_d;
        end
    end
    assign sel_data = tp ? {{5{bar_q[2]}}, {6{bar_q[1]}}, {5{bar_q[0]}}} : cur_src_q[0] ? s1_data : s0_data;
`else
    assign tp       = 1'b0;
    assign sel_data = cur_src_q[0] ? s1_data : s0_data;
`endif
    assign sel_valid   = tp | (cur_src_q[0] ? s1_valid : s0_valid);
    assign sel_vs_edge = ~tp & (cur_src_q[0] ? s1_vsync & ~s1_vsync_q : s0_vsync & ~s0_vsync_q);
    assign fwd         = state_q == XFER && sel_valid;
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB;
            cur_src_q      <= '0;
            last_q         <= 1'b1;
            load_cnt_q     <= '0;
            pix_cnt_q      <= '0;
            short_q        <= 1'b0;
            datain_q       <= '0;
            datain_valid_q <= 1'b0;
            s0_vsync_q     <= 1'b0;
            s1_vsync_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_src_q      <= cur_src_d;
            last_q         <= last_d;
            load_cnt_q     <= load_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            short_q        <= short_d;
            datain_q       <= datain_d;
            datain_valid_q <= datain_valid_d;
            s0_vsync_q     <= s0_vsync;
            s1_vsync_q     <= s1_vsync;
        end
    end
    always_comb begin
        state_d        = state_q;
        cur_src_d      = cur_src_q;
        last_d         = last_q;
        pix_cnt_d      = pix_cnt_q;
        short_d        = short_q;
        pix_inc        = pix_cnt_q + PW'(sel_valid);
        load_cnt_d     = state_q == LOAD ? load_cnt_q + 1'b1 : '0;
        datain_valid_d = fwd || state_q == PAD;
        datain_d       = fwd ? sel_data : '0;
        case (state_q)
            ARB: begin
                if (s0_en || s1_en) begin
                    last_d    = (s0_en && s1_en) ? ~last_q : s1_en;
                    cur_src_d = {1'b0, last_d};
                    state_d   = WAIT_VS;
                end
`ifdef WFS_TESTPAT_EN
                else begin
                    cur_src_d = 2'd2;
                    state_d   = LOAD;
                end
`endif
            end
            WAIT_VS: state_d = sel_vs_edge ? LOAD : WAIT_VS;
            LOAD: begin
                pix_cnt_d = '0;
                short_d   = 1'b0;
                state_d   = load_cnt_q == LW'(LOAD_CYC - 1) ? XFER : LOAD;
            end
            XFER: begin
                // the pixel of this cycle counts before a same-cycle vsync ends the frame
                pix_cnt_d = pix_inc;
                if (pix_inc == PW'(FRAME_PIX)) begin
                    state_d = DONE;
                end else if (sel_vs_edge) begin
                    short_d = 1'b1;
                    state_d = pix_inc[3:0] != 4'd0 ? PAD : DONE;
                end
            end
            PAD: begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                state_d   = pix_cnt_d[3:0] == 4'd0 ? DONE : PAD;
            end
            default: state_d = ARB;
        endcase
    end
    always_comb begin
        wr_load      = state_q == LOAD;
        frame_done   = state_q == DONE;
        frame_short  = state_q == DONE && short_q;
        busy         = state_q != ARB;
        datain       = datain_q;
        datain_valid = datain_valid_q;
        cur_src      = cur_src_q;
    end
endmodule

// File: tb/tb_wfifo_frame_sched.sv
// tb_wfifo_frame_sched: frame vectors, a reset-mid-frame sequence and random frames against a frame-level model.
module tb_wfifo_frame_sched;
    localparam int FP       = 2048;
    localparam int LOAD_CYC = 32;
    logic        rst_n, wr_clk;
    logic        s0_en, s1_en, s0_vsync, s1_vsync, s0_valid, s1_valid;
    logic [15:0] s0_data, s1_data;
    logic        wr_load, datain_valid, frame_done, frame_short, busy;
    logic [15:0] datain;
    logic [1:0]  cur_src;

    wfifo_frame_sched #(.FRAME_PIX(FP), .LOAD_CYC(LOAD_CYC), .H_PIX(640)) dut (
        .rst_n(rst_n), .wr_clk(wr_clk),
        .s0_en(s0_en), .s1_en(s1_en), .s0_vsync(s0_vsync), .s1_vsync(s1_vsync),
        .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_data(s0_data), .s1_data(s1_data),
        .wr_load(wr_load), .datain_valid(datain_valid), .datain(datain), .cur_src(cur_src),
        .frame_done(frame_done), .frame_short(frame_short), .busy(busy)
    );

    typedef struct {
        bit e0;
        bit e1;
        int npix;
        bit same;
        int src;
        int total;
        bit shrt;
    } vec_t;

    vec_t        tbl[9];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          load_seen;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_src = 1;

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (datain_valid) got_q.push_back(datain);
        if (wr_load) load_seen++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic idle();
        s0_en = 0; s1_en = 0; s0_vsync = 0; s1_vsync = 0;
        s0_valid = 0; s1_valid = 0; s0_data = 0; s1_data = 0;
    endtask

    task automatic set_vs(input int sel, input logic v);
        if (sel == 1) s1_vsync = v; else s0_vsync = v;
    endtask

    task automatic set_sel(input int sel, input logic v, input logic [15:0] d);
        if (sel == 1) begin s1_valid = v; s1_data = d; end
        else begin s0_valid = v; s0_data = d; end
    endtask

    // random traffic on both sources; only the other source's vsync is disturbed
    task automatic junk(input int sel);
        s0_valid = 1'($urandom); s0_data = 16'($urandom);
        s1_valid = 1'($urandom); s1_data = 16'($urandom);
        s0_en = 1'($urandom); s1_en = 1'($urandom);
        if (sel == 1) s0_vsync = 1'($urandom); else s1_vsync = 1'($urandom);
    endtask

    function automatic int pick(input bit e0, input bit e1);
        return (e0 && e1) ? int'(last_src == 0) : int'(e1);
    endfunction

    // called in an ARB cycle; returns in the ARB cycle after the frame
    task automatic do_frame(input vec_t v);
        int sent = 0;
        int t = 0;
        int bi = -1;
        logic [15:0] d;
        s0_en = v.e0; s1_en = v.e1;
        exp_q.delete(); got_q.delete(); load_seen = 0;
        step();
        junk(v.src); set_vs(v.src, 1'b1); step();
        set_vs(v.src, 1'b0);
        repeat (LOAD_CYC) begin junk(v.src); step(); end
        while (sent < v.npix) begin
            junk(v.src);
            if ($urandom_range(0, 3) != 0) begin
                d = 16'($urandom);
                set_sel(v.src, 1'b1, d);
                exp_q.push_back(d);
                sent++;
                if (sent == v.npix && v.npix < FP && v.same) set_vs(v.src, 1'b1);
            end else set_sel(v.src, 1'b0, 16'($urandom));
            step();
        end
        if (v.npix < FP && !(v.same && v.npix > 0)) begin
            junk(v.src); set_sel(v.src, 1'b0, 16'h0); set_vs(v.src, 1'b1); step();
        end
        idle();
        while (!frame_done && t < 64) begin step(); t++; end
        check("frame_done", frame_done, 1);
        check("frame_short", frame_short, v.shrt);
        check("cur_src", cur_src, v.src);
        step();
        check("arb_gap_busy_done", {busy, frame_done}, 0);
        while (exp_q.size() % 16 != 0) exp_q.push_back(16'h0);
        check("word_count", got_q.size(), v.total);
        check("frame_len_model", got_q.size(), exp_q.size());
        check("wr_load_cycles", load_seen, LOAD_CYC);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bi < 0 && got_q[i] !== exp_q[i]) bi = i;
        check("frame_data_bad_idx", bi, -1);
        last_src = v.src;
    endtask

`ifdef WFS_TESTPAT_EN
    function automatic logic [15:0] tp_pix(input int i);
        logic [2:0] b;
        b = 3'((i % 640) / 80);
        return {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
    endfunction
`endif

    initial begin
        vec_t v;
        int   t;
        int   nb;
        bit   [1:0] r;
        tbl[0] = '{1'b1, 1'b0, FP,   1'b0, 0, FP,   1'b0};
        tbl[1] = '{1'b1, 1'b0, 1000, 1'b1, 0, 1008, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 992,  1'b0, 0, 992,  1'b1};
        tbl[3] = '{1'b0, 1'b1, 5,    1'b0, 1, 16,   1'b1};
        tbl[4] = '{1'b1, 1'b1, 20,   1'b1, 0, 32,   1'b1};
        tbl[5] = '{1'b1, 1'b1, 17,   1'b0, 1, 32,   1'b1};
        tbl[6] = '{1'b1, 1'b1, 16,   1'b1, 0, 16,   1'b1};
        tbl[7] = '{1'b1, 1'b1, 1,    1'b0, 1, 16,   1'b1};
        tbl[8] = '{1'b0, 1'b1, 0,    1'b0, 1, 0,    1'b1};
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", {wr_load, datain_valid, datain, cur_src, frame_done, frame_short, busy}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) do_frame(tbl[i]);

        // pixels during LOAD are dropped, then reset lands mid-XFER
        got_q.delete();
        s0_en = 1; s1_en = 0; step();
        s0_vsync = 1; s1_valid = 1; s1_data = 16'hBEEF; step();
        s0_vsync = 0; s0_valid = 1;
        repeat (LOAD_CYC) begin s0_data = 16'($urandom); step(); end
        s0_data = 16'h1234; step();
        check("load_pixels_dropped", got_q.size(), 0);
        check("first_pixel_latency", {datain_valid, datain}, {1'b1, 16'h1234});
        repeat (5) begin s0_data = 16'($urandom); step(); end
        check("pre_reset_active", {busy, datain_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {wr_load, datain_valid, datain, cur_src, frame_done, frame_short, busy}, 0);
        step();
        idle();
        rst_n = 1'b1;
        last_src = 1;

        for (int i = 0; i < 12; i++) begin
            r      = 2'($urandom_range(1, 3));
            v.e0   = r[0];
            v.e1   = r[1];
            v.npix = ($urandom_range(0, 9) == 0) ? FP : int'($urandom_range(0, 200));
            v.same = 1'($urandom);
            v.src  = pick(v.e0, v.e1);
            v.total = (v.npix == FP) ? FP : ((v.npix + 15) / 16) * 16;
            v.shrt = v.npix != FP;
            do_frame(v);
        end

        idle();
`ifdef WFS_TESTPAT_EN
        got_q.delete();
        t = 0;
        while (!frame_done && t < FP + 100) begin step(); t++; end
        check("tp_cur_src", cur_src, 2);
        step();
        check("tp_count", got_q.size(), FP);
        if (got_q.size() > 560) begin
            check("tp_pix0", got_q[0], tp_pix(0));
            check("tp_pix80", got_q[80], tp_pix(80));
            check("tp_pix560", got_q[560], tp_pix(560));
        end
`else
        nb = 0;
        repeat (20) begin step(); if (busy) nb++; end
        check("idle_without_enables", nb, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wfifo_frame_sched.md
# wfifo_frame_sched

Write-side frame scheduler in front of the DDR3 write FIFO/packer. It shares the single 16-bit pixel write path between two synchronous pixel sources (camera and processed/overlay stream) at whole-frame granularity, and issues the per-frame `wr_load` FIFO-flush request. It forwards the selected source's pixels and pads short frames to a 16-pixel (256-bit) word boundary, so the downstream 16→256 packer never straddles frames.

## Interface
- `FRAME_PIX`, 307200: pixels per full frame (640×480); must be a multiple of 16.
- `LOAD_CYC`, 32: cycles `wr_load` is held high per frame; must be ≥ 20.
- `H_PIX`, 640: line width, used only by the test pattern.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_clk` in 1: clock; all sources are synchronous to it.
- `s0_en`, `s1_en` in 1: source enables, sampled only in ARB.
- `s0_vsync`, `s1_vsync` in 1: frame sync; a rising edge starts a frame.
- `s0_valid`, `s1_valid` in 1: pixel strobes; no backpressure.
- `s0_data`, `s1_data` in 16: RGB565 pixels.
- `wr_load` out 1: FIFO flush request to the packer/FIFO controller.
- `datain_valid` out 1: pixel strobe to the packer.
- `datain` out 16: pixel to the packer.
- `cur_src` out 2: source of the current/last frame (0 = s0, 1 = s1, 2 = test pattern).
- `frame_done` out 1: 1-cycle pulse at the end of each frame.
- `frame_short` out 1: 1-cycle pulse together with `frame_done` when the frame was terminated early.
- `busy` out 1: high in every state except ARB.

## Operation
- **States:** ARB, WAIT_VS, LOAD, XFER, PAD, DONE. Reset state is ARB.
- **ARB:** frame-level round-robin.
  - If both sources are enabled, pick the one not used last.
  - If one is enabled, pick it.
  - If none is enabled, stay in ARB.
  - On a pick: latch `cur_src`, go to WAIT_VS.
- **WAIT_VS:** wait for a rising edge of the selected vsync. Edge detect is `vsync & ~vsync_d` with one register. Then go to LOAD.
- **LOAD:** hold `wr_load`=1 for exactly `LOAD_CYC` cycles; all pixels are dropped. Clear the pixel counter `pix_cnt` (width `$clog2(FRAME_PIX+1)`). Go to XFER.
- **XFER:** each selected-source valid pixel is forwarded and increments `pix_cnt`.
  - `pix_cnt` reaching `FRAME_PIX` → DONE.
  - A selected-vsync rising edge before that → PAD if `pix_cnt[3:0]≠0`, else DONE. Either way the frame is marked short.
  - If a valid pixel and the vsync edge arrive in the same cycle, the pixel is forwarded first, then termination is evaluated on the updated count.
- **PAD:** emit `datain`=0 with `datain_valid`=1 every cycle until `pix_cnt[3:0]`=0, then go to DONE. Source pixels are dropped during PAD.
- **DONE:** one cycle. Pulse `frame_done`, plus `frame_short` if the frame was marked short. Go to ARB.
- **Dropping:** the non-selected source is always dropped. Pixels outside XFER are dropped. Pixels beyond `FRAME_PIX` cannot occur, because the FSM has already left XFER.
- **Enable changes:** deasserting `s*_en` mid-frame does not abort the frame; it takes effect at the next ARB.
- A vsync edge that terminates a frame is consumed. The next frame on that source waits for its next edge.

## Timing
- **Reset values:** all outputs 0; FSM in ARB; round-robin pointer selects s0 first.
- **Forwarding latency:** `datain`/`datain_valid` are registered, 1 cycle after `s*_valid`/`s*_data`.
- **WAIT_VS → LOAD:** the vsync edge seen in cycle N gives `wr_load`=1 in cycles N+1 … N+`LOAD_CYC`. The first pixel can be forwarded if valid in cycle N+`LOAD_CYC`+1.
- **Word count:** forwarded pixels plus pad pixels per frame is always a multiple of 16.
- **Reset mid-frame:** all outputs are cleared immediately (asynchronous). The partial word downstream is discarded by the next `wr_load`.
- **Back-to-back frames:** exactly one ARB cycle separates DONE from the next WAIT_VS.

## Configuration
- **`WFS_TESTPAT_EN` defined:** when ARB sees both enables low, it selects `cur_src`=2.
  - LOAD runs immediately, with no vsync wait.
  - XFER then emits `FRAME_PIX` pixels, one per cycle: 8 vertical colour bars of `H_PIX/8` px, colour = RGB565 of bar index bits {b2 red, b1 green, b0 blue} at full scale.
  - Then DONE, and the next frame repeats.
- **Not defined:** no pattern logic is built, `cur_src` never equals 2, and ARB idles while both enables are low.

## Test plan
- **Single source, full frame.** Stimulus: `s0_en`=1, one vsync edge, then 307200 valid pixels. Required: `wr_load` high exactly 32 cycles; `datain_valid` count 307200; one `frame_done` with `frame_short`=0; `cur_src`=0.
- **Short frame with padding.** Stimulus: 1000 pixels, then a vsync edge. Required: 8 zero pad pixels (total 1008); `frame_done`+`frame_short` in the same cycle.
- **Aligned short frame.** Stimulus: 992 pixels, then a vsync edge. Required: no pad pixels; `frame_short`=1.
- **Round-robin.** Stimulus: both enables high, both sources running. Required: `cur_src` sequence 0,1,0,1; s1 pixels are never forwarded during an s0 frame.
- **Pixels during LOAD and reset mid-frame.** Stimulus: pixels during LOAD, then `rst_n` low mid-XFER. Required: no pixels forwarded during LOAD; on reset, all outputs go to 0 at once and the FSM is in ARB.
- **`WFS_TESTPAT_EN`.** Stimulus: both enables low. Required: `cur_src`=2; pixel 0 = 16'h0000; pixel 80 = 16'h001F; pixel 560 = 16'hFFFF.
